sample_mixer: RTL and testbench
===============================

# sample_mixer

Parametrised N-channel audio sample mixer/selector between the sample sources (music player, MIDI synth, future generators) and the AC97 codec / wave display. It generalises the two-source select-and-flop stage into N channels with two modes, single-channel select and saturating mix of enabled channels. It produces one registered sample per codec frame, and an optional click-free gain fade applies whenever the selection changes.

## Interface
- NUM_CH, 4: number of input channels (≥2)
- SAMPLE_WIDTH, 16: signed two's-complement sample width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_in  in  NUM_CH*SAMPLE_WIDTH  channel i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- new_sample_in  in  NUM_CH  per-channel one-cycle strobe, sample_in[i] valid
- new_frame  in  1  codec frame strobe (one cycle)
- mode  in  1  0 = select, 1 = mix
- sel  in  $clog2(NUM_CH)  channel used in select mode
- ch_enable  in  NUM_CH  channel participates in mix mode
- sample_out  out  SAMPLE_WIDTH  registered output sample
- new_sample_out  out  1  one-cycle pulse, sample_out updated
- busy  out  1  frame computation in progress
- overrun  out  1  sticky: new_frame arrived while busy; cleared only by reset

## Operation
- Hold registers: hold[i] <= sample_in[i] on new_sample_in[i]; otherwise retained.
- Main FSM: IDLE -> ACCUM -> OUT -> IDLE.
  - IDLE: on new_frame, snapshot all hold[] into frame bank, sample mode/sel/ch_enable, clear accumulator, idx=0 -> ACCUM.
  - ACCUM: one channel per cycle, idx 0..NUM_CH-1; add sign-extended bank[idx] if it contributes -> OUT after idx=NUM_CH-1.
  - OUT: saturate, apply gain, register sample_out, pulse new_sample_out -> IDLE.
- Contribution: select mode, only channel == active sel (ch_enable ignored); mix mode, channels with ch_enable=1. None enabled -> 0.
- Accumulator width SAMPLE_WIDTH+$clog2(NUM_CH); result saturated to [-2^(W-1), 2^(W-1)-1] before gain.
- Gain stage: out = (sat * gain) >>> 4, gain 0..16 (GAIN_FULL=16), arithmetic shift (floor).
- new_frame while busy: ignored, overrun <= 1, no extra pulse.
- new_sample_in coincident with accepted new_frame: hold updates, snapshot takes previous value.
- Reset mid-frame: FSM to IDLE, no pulse; all state cleared.
- Reset values: sample_out 0, new_sample_out 0, busy 0, overrun 0, hold[]/bank 0, gain 16, active mode 0, active sel 0, fade state STEADY.

## Timing
- new_frame accepted in cycle t: ACCUM t+1..t+NUM_CH, OUT t+NUM_CH+1, sample_out/new_sample_out visible t+NUM_CH+2.
- busy high t+1 through t+NUM_CH+1 inclusive; next new_frame accepted from t+NUM_CH+2.
- Minimum frame spacing NUM_CH+2 cycles; codec frames (~48 kHz) are far slower.
- Fade state advances once per frame, in OUT.

## Configuration
- SAMPLE_MIXER_FADE_EN defined: fade FSM STEADY/FADE_OUT/FADE_IN. Requested {mode,sel} differing from active in STEADY -> FADE_OUT; gain -1 per frame; frame with gain 0 outputs 0, then active <= requested, FADE_IN; gain +1 per frame to 16 -> STEADY. Request change during FADE_IN -> FADE_OUT from current gain. Change during FADE_OUT: adopted at gain 0.
- Not defined: gain fixed at 16; requested {mode,sel} becomes active at the next accepted new_frame.
- ch_enable changes never fade.

## Structure
- Package sample_mixer_pkg: GAIN_BITS=4, GAIN_FULL=16, main-FSM and fade-FSM state enums, saturate function.
- Sub-module fade_gain_ctrl: fade FSM, gain register, active mode/sel; compiled only under SAMPLE_MIXER_FADE_EN.

## Test plan
- Reset, then new_frame -> new_sample_out pulse exactly 6 cycles later (NUM_CH=4), sample_out=0x0000, busy high 5 cycles.
- Select mode, sel=2, hold[2]=0x1234, others 0x7FFF -> sample_out=0x1234.
- Mix mode, all enabled: all 0x7000 -> 0x7FFF; all 0x9000 -> 0x8000; ch0=0x1000, ch1=0xF000, others disabled -> 0x0000.
- new_frame at t and t+2 -> one pulse at t+6, overrun=1 until reset.
- FADE_EN, hold[0]=0x4000, hold[1]=0x2000, sel 0->1 -> frames 0x3C00, 0x3800, … 0x0000 (16 frames), then 0x0200, 0x0400, … 0x2000; without macro next frame = 0x2000.
- new_sample_in[0] with value 0x0100 coincident with accepted new_frame (hold[0]=0x0050, sel=0) -> this frame 0x0050, next frame 0x0100.

Source files
------------

// File: rtl/sample_mixer_pkg.sv
// sample_mixer_pkg: shared constants, FSM state types and the saturation
// helper for the sample_mixer block.
//   GAIN_BITS  - shift applied after the gain multiply (gain is in 1/16 steps)
//   GAIN_FULL  - unity gain value
//   mix_state_t  - main frame FSM (IDLE -> ACCUM -> OUT)
//   fade_state_t - gain fade FSM (only used when SAMPLE_MIXER_FADE_EN is set)
package sample_mixer_pkg;

    localparam int GAIN_BITS = 4;
    localparam int GAIN_FULL = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } mix_state_t;

    typedef enum logic [1:0] {
        FD_STEADY   = 2'd0,
        FD_FADE_OUT = 2'd1,
        FD_FADE_IN  = 2'd2
    } fade_state_t;

    // Clamp a signed value into the range of a w-bit two's-complement number.
    // Caller truncates the result to w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int                w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/fade_gain_ctrl.sv
// fade_gain_ctrl: click-free selection change. Owns the output gain and the
// active {mode, sel}. Advances once per frame (i_step, asserted in the mixer's
// OUT cycle). A request that differs from the active selection ramps the gain
// down by one per frame; the frame at gain 0 outputs silence and switches the
// active selection, after which gain ramps back up to GAIN_FULL.
// Only compiled when SAMPLE_MIXER_FADE_EN is defined.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   i_step          - advance one frame
//   i_req_mode/sel  - requested selection sampled at frame start
//   o_gain          - gain to apply to the frame being output this cycle
//   o_act_mode/sel  - selection currently used for accumulation
`ifdef SAMPLE_MIXER_FADE_EN
module fade_gain_ctrl
    import sample_mixer_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_step,
    input  logic                 i_req_mode,
    input  logic [SEL_W-1:0]     i_req_sel,
    output logic [GAIN_BITS:0]   o_gain,
    output logic                 o_act_mode,
    output logic [SEL_W-1:0]     o_act_sel
);

    localparam int GAIN_W = GAIN_BITS + 1;

    fade_state_t         r_state;
    fade_state_t         w_state_nxt;
    logic [GAIN_W-1:0]   r_gain;
    logic [GAIN_W-1:0]   w_gain_nxt;
    logic                r_act_mode;
    logic [SEL_W-1:0]    r_act_sel;
    logic                w_req_diff;
    logic                w_adopt;

    assign w_req_diff = {i_req_mode, i_req_sel} != {r_act_mode, r_act_sel};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FD_STEADY;
            r_gain     <= GAIN_W'(GAIN_FULL);
            r_act_mode <= 1'b0;
            r_act_sel  <= '0;
        end else if (i_step) begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            if (w_adopt) begin
                r_act_mode <= i_req_mode;
                r_act_sel  <= i_req_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_adopt     = 1'b0;
        case (r_state)
            FD_STEADY: begin
                if (w_req_diff) begin
                    w_gain_nxt  = r_gain - 1'b1;
                    w_state_nxt = FD_FADE_OUT;
                end
            end
            FD_FADE_OUT: begin
                // Request changes while fading out are simply picked up at gain 0.
                w_gain_nxt = r_gain - 1'b1;
            end
            FD_FADE_IN: begin
                if (w_req_diff) begin
                    // Reverse from wherever the ramp currently is.
                    w_state_nxt = FD_FADE_OUT;
                    if (r_gain != '0) w_gain_nxt = r_gain - 1'b1;
                end else begin
                    w_gain_nxt = r_gain + 1'b1;
                    if (w_gain_nxt == GAIN_W'(GAIN_FULL)) w_state_nxt = FD_STEADY;
                end
            end
            default: w_state_nxt = FD_STEADY;
        endcase
        // Silent frame reached: switch sources now, ramp up from next frame.
        if (w_state_nxt == FD_FADE_OUT && w_gain_nxt == '0) begin
            w_adopt     = 1'b1;
            w_state_nxt = FD_FADE_IN;
        end
    end

    assign o_gain     = w_gain_nxt;
    assign o_act_mode = r_act_mode;
    assign o_act_sel  = r_act_sel;

endmodule
`endif

// File: rtl/sample_mixer.sv
// sample_mixer: N-channel sample selector / saturating mixer feeding the codec.
// Each channel's latest sample is held; on new_frame the holds are snapshot and
// summed one channel per cycle, saturated, scaled by gain and registered.
// Optional feature macro: SAMPLE_MIXER_FADE_EN (gain fade on selection change);
// without it gain is unity and the requested {mode, sel} applies immediately.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   sample_in       - channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   new_sample_in   - per-channel strobe loading the hold register
//   new_frame       - codec frame strobe, starts a frame computation
//   mode            - 0 select, 1 mix
//   sel             - channel for select mode
//   ch_enable       - channel participation in mix mode
//   sample_out      - registered output sample
//   new_sample_out  - one-cycle pulse when sample_out updates
//   busy            - frame computation in progress
//   overrun         - sticky: new_frame seen while busy
module sample_mixer
    import sample_mixer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]   sample_in,
    input  logic [NUM_CH-1:0]                new_sample_in,
    input  logic                             new_frame,
    input  logic                             mode,
    input  logic [$clog2(NUM_CH)-1:0]        sel,
    input  logic [NUM_CH-1:0]                ch_enable,
    output logic [SAMPLE_WIDTH-1:0]          sample_out,
    output logic                             new_sample_out,
    output logic                             busy,
    output logic                             overrun
);

    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int ACC_W  = SAMPLE_WIDTH + IDX_W;
    localparam int GAIN_W = GAIN_BITS + 1;
    localparam int PROD_W = SAMPLE_WIDTH + GAIN_W + 1;

    mix_state_t                           r_state;
    mix_state_t                           w_state_nxt;
    logic                                 w_accept;
    logic                                 w_out_step;

    logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0]  r_hold;
    logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0]  r_bank;
    logic [NUM_CH-1:0]                    r_frame_en;
    logic                                 r_req_mode;
    logic [IDX_W-1:0]                     r_req_sel;
    logic signed [ACC_W-1:0]              r_acc;
    logic [IDX_W-1:0]                     r_idx;

    logic                                 w_act_mode;
    logic [IDX_W-1:0]                     w_act_sel;
    logic [GAIN_W-1:0]                    w_gain;
    logic                                 w_contrib;
    logic signed [ACC_W-1:0]              w_addend;
    logic signed [SAMPLE_WIDTH-1:0]       w_sat;
    logic signed [PROD_W-1:0]             w_prod;

    logic [SAMPLE_WIDTH-1:0]              r_sample_out;
    logic                                 r_new_out;
    logic                                 r_overrun;

    // ---------------- main FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_out_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (new_frame) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (r_idx == IDX_W'(NUM_CH - 1)) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                w_out_step  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // ---------------- selection / gain source ----------------
`ifdef SAMPLE_MIXER_FADE_EN
    fade_gain_ctrl #(
        .SEL_W (IDX_W)
    ) u_fade (
        .clk        (clk),
        .reset      (reset),
        .i_step     (w_out_step),
        .i_req_mode (r_req_mode),
        .i_req_sel  (r_req_sel),
        .o_gain     (w_gain),
        .o_act_mode (w_act_mode),
        .o_act_sel  (w_act_sel)
    );
`else
    // The request sampled at frame start is the active selection.
    assign w_act_mode = r_req_mode;
    assign w_act_sel  = r_req_sel;
    assign w_gain     = GAIN_W'(GAIN_FULL);
`endif

    // ---------------- datapath ----------------
    assign w_contrib = w_act_mode ? r_frame_en[r_idx] : (r_idx == w_act_sel);
    assign w_addend  = ACC_W'($signed(r_bank[r_idx]));
    assign w_sat     = SAMPLE_WIDTH'(saturate(64'(r_acc), SAMPLE_WIDTH));
    // Gain is unsigned 0..16; zero-extend before the signed multiply.
    assign w_prod    = PROD_W'(w_sat) * PROD_W'($signed({1'b0, w_gain}));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold       <= '0;
            r_bank       <= '0;
            r_frame_en   <= '0;
            r_req_mode   <= 1'b0;
            r_req_sel    <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_sample_out <= '0;
            r_new_out    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Holds update on the same edge as a snapshot, so the bank
            // captures the value from before a coincident strobe.
            for (int i = 0; i < NUM_CH; i++) begin
                if (new_sample_in[i]) r_hold[i] <= sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end

            r_new_out <= 1'b0;
            if (new_frame && busy) r_overrun <= 1'b1;

            if (w_accept) begin
                r_bank     <= r_hold;
                r_frame_en <= ch_enable;
                r_req_mode <= mode;
                r_req_sel  <= sel;
                r_acc      <= '0;
                r_idx      <= '0;
            end

            if (r_state == ST_ACCUM) begin
                if (w_contrib) r_acc <= r_acc + w_addend;
                r_idx <= r_idx + 1'b1;
            end

            if (w_out_step) begin
                r_sample_out <= SAMPLE_WIDTH'(w_prod >>> GAIN_BITS);
                r_new_out    <= 1'b1;
            end
        end
    end

    assign sample_out     = r_sample_out;
    assign new_sample_out = r_new_out;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_sample_mixer.sv
module tb_sample_mixer;

    localparam int NUM_CH = 4;
    localparam int W      = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_CH*W-1:0]   sample_in = '0;
    logic [NUM_CH-1:0]     new_sample_in = '0;
    logic                  new_frame = 1'b0;
    logic                  mode = 1'b0;
    logic [1:0]            sel = '0;
    logic [NUM_CH-1:0]     ch_enable = '0;
    logic [W-1:0]          sample_out;
    logic                  new_sample_out;
    logic                  busy;
    logic                  overrun;

    int errors = 0;
    int checks = 0;

    sample_mixer #(.NUM_CH(NUM_CH), .SAMPLE_WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .new_sample_in  (new_sample_in),
        .new_frame      (new_frame),
        .mode           (mode),
        .sel            (sel),
        .ch_enable      (ch_enable),
        .sample_out     (sample_out),
        .new_sample_out (new_sample_out),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame result is computed arithmetically when a frame is accepted and
    // released after the documented latency.
    int          m_hold [NUM_CH];
    int          m_act_mode, m_act_sel, m_gain, m_phase, m_rem, m_pending;
    bit          m_valid = 1'b0;
    logic        exp_pulse = 1'b0, exp_busy = 1'b0, exp_overrun = 1'b0;
    logic [15:0] exp_out = '0;

    initial begin
        int  sum, sat, g, rmode, rsel;
        bit  differs;
        forever begin
            @(posedge clk);
            if (reset) begin
                foreach (m_hold[i]) m_hold[i] = 0;
                m_act_mode = 0; m_act_sel = 0; m_gain = 16; m_phase = 0;
                m_rem = 0; m_pending = 0;
                exp_pulse = 0; exp_overrun = 0; exp_out = '0;
                m_valid = 1'b1;
            end else begin
                exp_pulse = 0;
                if (m_rem > 0) begin
                    if (new_frame) exp_overrun = 1;
                    m_rem--;
                    if (m_rem == 0) begin
                        exp_pulse = 1;
                        exp_out   = 16'(m_pending);
                    end
                end else if (new_frame) begin
                    rmode = int'(mode);
                    rsel  = int'(sel);
`ifndef SAMPLE_MIXER_FADE_EN
                    m_act_mode = rmode;
                    m_act_sel  = rsel;
`endif
                    sum = 0;
                    for (int i = 0; i < NUM_CH; i++)
                        if (m_act_mode != 0 ? ch_enable[i] : (i == m_act_sel)) sum += m_hold[i];
                    sat = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
`ifdef SAMPLE_MIXER_FADE_EN
                    // phase 0 steady, 1 fading out, 2 fading in
                    differs = (rmode != m_act_mode) || (rsel != m_act_sel);
                    if (m_phase == 0) begin
                        if (differs) begin m_phase = 1; m_gain--; end
                    end else if (m_phase == 1) begin
                        m_gain--;
                    end else begin
                        if (differs) begin
                            m_phase = 1;
                            if (m_gain > 0) m_gain--;
                        end else begin
                            m_gain++;
                            if (m_gain == 16) m_phase = 0;
                        end
                    end
                    g = m_gain;
                    if (m_phase == 1 && m_gain == 0) begin
                        m_act_mode = rmode; m_act_sel = rsel; m_phase = 2;
                    end
`else
                    differs = 1'b0;
                    g = 16;
`endif
                    m_pending = (sat * g) >>> 4;
                    m_rem = NUM_CH + 1;
                end
                for (int i = 0; i < NUM_CH; i++)
                    if (new_sample_in[i]) m_hold[i] = int'($signed(sample_in[i*W +: W]));
            end
            exp_busy = (m_rem > 0);
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid && !reset) begin
                chk("pulse",   32'(new_sample_out), 32'(exp_pulse));
                chk("busy",    32'(busy),           32'(exp_busy));
                chk("overrun", 32'(overrun),        32'(exp_overrun));
                chk("out",     32'(sample_out),     32'(exp_out));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int ch, input logic [15:0] v);
        @(negedge clk);
        sample_in[ch*W +: W] = v;
        new_sample_in = '0;
        new_sample_in[ch] = 1'b1;
        @(negedge clk);
        new_sample_in = '0;
    endtask

    // Issue one frame (optionally with a coincident channel load) and wait for its pulse.
    task automatic run_frame(input int ld_ch, input logic [15:0] ld_val,
                             output logic [15:0] v, output int lat, output int nbusy);
        @(negedge clk);
        new_frame = 1'b1;
        if (ld_ch >= 0) begin
            sample_in[ld_ch*W +: W] = ld_val;
            new_sample_in[ld_ch] = 1'b1;
        end
        @(negedge clk);
        new_frame = 1'b0;
        new_sample_in = '0;
        lat = 1;
        nbusy = 0;
        while (!new_sample_out && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (!new_sample_out) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no new_sample_out within %0d cycles", lat);
        end
        v = sample_out;
    endtask

    // Apply a selection; with fading enabled run enough frames to settle.
    task automatic set_sel(input logic m, input logic [1:0] s);
        logic [15:0] v;
        int lat, nb;
        @(negedge clk);
        mode = m;
        sel  = s;
`ifdef SAMPLE_MIXER_FADE_EN
        repeat (32) run_frame(-1, 16'h0, v, lat, nb);
`else
        v = '0; lat = 0; nb = 0;
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] v;
        int lat, nb, npulse, first;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out",   32'(sample_out),     32'h0);
        chk("rst_pulse", 32'(new_sample_out), 32'h0);
        chk("rst_busy",  32'(busy),           32'h0);
        chk("rst_ovr",   32'(overrun),        32'h0);

        // Latency / busy window with all-zero holds.
        run_frame(-1, 16'h0, v, lat, nb);
        chk("lat",      32'(lat), 32'd6);
        chk("zero_out", 32'(v),   32'h0);
        chk("busy_len", 32'(nb),  32'd5);

        // Select mode.
        load(0, 16'h7FFF); load(1, 16'h7FFF); load(2, 16'h1234); load(3, 16'h7FFF);
        set_sel(1'b0, 2'd2);
        run_frame(-1, 16'h0, v, lat, nb);
        chk("sel2", 32'(v), 32'h1234);

        // Mix mode.
        ch_enable = 4'hF;
        set_sel(1'b1, 2'd2);
        for (int i = 0; i < NUM_CH; i++) load(i, 16'h7000);
        run_frame(-1, 16'h0, v, lat, nb);
        chk("mix_pos_sat", 32'(v), 32'h7FFF);
        for (int i = 0; i < NUM_CH; i++) load(i, 16'h9000);
        run_frame(-1, 16'h0, v, lat, nb);
        chk("mix_neg_sat", 32'(v), 32'h8000);
        load(0, 16'h1000); load(1, 16'hF000);
        ch_enable = 4'b0011;
        run_frame(-1, 16'h0, v, lat, nb);
        chk("mix_cancel", 32'(v), 32'h0000);
        ch_enable = 4'b0000;
        run_frame(-1, 16'h0, v, lat, nb);
        chk("mix_none", 32'(v), 32'h0000);
        ch_enable = 4'b0101;
        run_frame(-1, 16'h0, v, lat, nb);
        chk("mix_0_2", 32'(v), 32'hA000);

        // Coincident sample strobe and frame: snapshot takes the old value.
        set_sel(1'b0, 2'd0);
        load(0, 16'h0050);
        run_frame(0, 16'h0100, v, lat, nb);
        chk("coinc_old", 32'(v), 32'h0050);
        run_frame(-1, 16'h0, v, lat, nb);
        chk("coinc_new", 32'(v), 32'h0100);

        // Selection change 0 -> 1.
        load(0, 16'h4000); load(1, 16'h2000);
        @(negedge clk);
        sel = 2'd1;
`ifdef SAMPLE_MIXER_FADE_EN
        for (int k = 1; k <= 16; k++) begin
            run_frame(-1, 16'h0, v, lat, nb);
            chk("fade_out", 32'(v), 32'((16 - k) * 32'h400));
        end
        for (int k = 1; k <= 16; k++) begin
            run_frame(-1, 16'h0, v, lat, nb);
            chk("fade_in", 32'(v), 32'(k * 32'h200));
        end
`else
        run_frame(-1, 16'h0, v, lat, nb);
        chk("switch", 32'(v), 32'h2000);
`endif

        // new_frame at t and t+2: one pulse at t+6, sticky overrun.
        @(negedge clk); new_frame = 1'b1;
        @(negedge clk); new_frame = 1'b0;
        @(negedge clk); new_frame = 1'b1;
        @(negedge clk); new_frame = 1'b0;
        npulse = 0; first = -1;
        for (int i = 4; i <= 14; i++) begin
            @(negedge clk);
            if (new_sample_out) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        chk("ovr_pulses", 32'(npulse), 32'd1);
        chk("ovr_lat",    32'(first),  32'd6);
        chk("ovr_sticky", 32'(overrun), 32'h1);

        // Reset in the middle of a frame: no pulse, everything cleared.
        @(negedge clk); new_frame = 1'b1;
        @(negedge clk); new_frame = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        npulse = 0;
        repeat (10) begin
            @(negedge clk);
            if (new_sample_out) npulse++;
        end
        chk("midrst_pulse", 32'(npulse),     32'd0);
        chk("midrst_ovr",   32'(overrun),    32'h0);
        chk("midrst_out",   32'(sample_out), 32'h0);
        chk("midrst_busy",  32'(busy),       32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
